// File: rtl/flash_reader.sv
// SPI flash word reader: after a power-up delay, accepts a CPU read request,
// sends READ (0x03) plus a 24-bit address over SPI mode 0, shifts in two
// bytes and returns them as one 16-bit word with a one-cycle ready pulse.
module flash_reader #(
    parameter int unsigned STARTUP_CYCLES = 10000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] flashReadAddr,
    input  logic        flashEnabled,
    output logic [15:0] flashByteRead,
    output logic        flashDataReady,
    output logic        flashClk,
    output logic        flashCs,
    output logic        flashMosi,
    input  logic        flashMiso
);

    localparam int unsigned CNT_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (STARTUP_CYCLES > 1) ? CNT_W'(STARTUP_CYCLES - 1) : '0;
    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [5:0] LAST_SEND_BIT = 6'd31;
    localparam logic [5:0] LAST_BIT = 6'd47;

    typedef enum logic [2:0] {
        STARTUP,
        IDLE,
        SEND,
        READ,
        DONE,
        WAIT_RELEASE
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] startup_cnt_reg, startup_cnt_next;
    logic [5:0]       bit_cnt_reg, bit_cnt_next;
    logic             phase_reg, phase_next;      // 0: SCK low half, 1: SCK high half
    logic [31:0]      shift_reg, shift_next;      // command + address, MSB leaves first
    logic [15:0]      rx_reg, rx_next;
    logic             cs_reg, cs_next;
    logic             sck_reg, sck_next;
    logic             mosi_reg, mosi_next;
    logic [15:0]      data_reg, data_next;
    logic             ready_reg, ready_next;

    // State and datapath registers; reset aborts any transfer in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= STARTUP;
            startup_cnt_reg <= '0;
            bit_cnt_reg     <= '0;
            phase_reg       <= 1'b0;
            shift_reg       <= '0;
            rx_reg          <= '0;
            cs_reg          <= 1'b1;
            sck_reg         <= 1'b0;
            mosi_reg        <= 1'b0;
            data_reg        <= '0;
            ready_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            startup_cnt_reg <= startup_cnt_next;
            bit_cnt_reg     <= bit_cnt_next;
            phase_reg       <= phase_next;
            shift_reg       <= shift_next;
            rx_reg          <= rx_next;
            cs_reg          <= cs_next;
            sck_reg         <= sck_next;
            mosi_reg        <= mosi_next;
            data_reg        <= data_next;
            ready_reg       <= ready_next;
        end
    end

    // Next-state and SPI bit sequencing: each bit is a low half then a high
    // half of SCK; MISO is captured on the edge that ends the high half.
    always_comb begin
        state_next       = state_reg;
        startup_cnt_next = startup_cnt_reg;
        bit_cnt_next     = bit_cnt_reg;
        phase_next       = phase_reg;
        shift_next       = shift_reg;
        rx_next          = rx_reg;
        cs_next          = cs_reg;
        sck_next         = sck_reg;
        mosi_next        = mosi_reg;
        data_next        = data_reg;
        ready_next       = 1'b0;

        case (state_reg)
            STARTUP: begin
                cs_next   = 1'b1;
                sck_next  = 1'b0;
                mosi_next = 1'b0;
                if (startup_cnt_reg == CNT_LAST) begin
                    state_next = IDLE;
                end else begin
                    startup_cnt_next = startup_cnt_reg + 1'b1;
                end
            end

            IDLE: begin
                if (flashEnabled) begin
                    shift_next   = {CMD_READ, flashReadAddr};
                    mosi_next    = CMD_READ[7];
                    cs_next      = 1'b0;
                    sck_next     = 1'b0;
                    bit_cnt_next = '0;
                    phase_next   = 1'b0;
                    state_next   = SEND;
                end
            end

            SEND, READ: begin
                if (!phase_reg) begin
                    sck_next   = 1'b1;
                    phase_next = 1'b1;
                end else begin
                    sck_next   = 1'b0;
                    phase_next = 1'b0;
                    if (state_reg == READ) begin
                        rx_next = {rx_reg[14:0], flashMiso};
                    end
                    if (bit_cnt_reg == LAST_BIT) begin
                        cs_next    = 1'b1;
                        mosi_next  = 1'b0;
                        data_next  = {rx_reg[14:0], flashMiso};
                        ready_next = 1'b1;
                        state_next = DONE;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                        if (state_reg == SEND) begin
                            shift_next = {shift_reg[30:0], 1'b0};
                            if (bit_cnt_reg == LAST_SEND_BIT) begin
                                mosi_next  = 1'b0;
                                state_next = READ;
                            end else begin
                                mosi_next = shift_reg[30];
                            end
                        end else begin
                            mosi_next = 1'b0;
                        end
                    end
                end
            end

            DONE: begin
                state_next = WAIT_RELEASE;
            end

            WAIT_RELEASE: begin
                if (!flashEnabled) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = STARTUP;
            end
        endcase
    end

    assign flashByteRead  = data_reg;
    assign flashDataReady = ready_reg;
    assign flashClk       = sck_reg;
    assign flashCs        = cs_reg;
    assign flashMosi      = mosi_reg;

endmodule
